// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU constants for the register-file writeback path.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 2;
    localparam int NUM_WB_REQ = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_DBG = 2;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus, register-file write port and decode hazard signals.
interface regfile_write_arbiter_if
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int DW      = DATA_W,
    parameter int AW      = ADDR_W,
    parameter int PTR_W   = ptr_width(NUM_REQ)
);
    // Req[i] plus its ReqRD/ReqData slices stay stable until Grant[i]=1;
    // the write is accepted in that cycle, and dropping Req before Grant is a no-op.
    logic [NUM_REQ-1:0]    Req;
    logic [NUM_REQ*AW-1:0] ReqRD;
    logic [NUM_REQ*DW-1:0] ReqData;
    logic [NUM_REQ-1:0]    Grant;
    logic [AW-1:0]         RS;
    logic [AW-1:0]         RT;
    logic                  RegWrite;
    logic [AW-1:0]         RD;
    logic [DW-1:0]         WriteData;
    logic                  Stall;
    logic [PTR_W-1:0]      Ptr;

    modport master (
        output Req, ReqRD, ReqData, RS, RT,
        input  Grant, RegWrite, RD, WriteData, Stall, Ptr
    );

    modport slave (
        input  Req, ReqRD, ReqData, RS, RT,
        output Grant, RegWrite, RD, WriteData, Stall, Ptr
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Grant,
    output logic [PTR_W-1:0]   Ptr
);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   idx;
    logic [NUM_REQ-1:0] grant_c;
    logic               found;

    // Scan Ptr, Ptr+1, ... with wraparound; the first requester seen wins.
    always_comb begin
        grant_c  = '0;
        next_ptr = ptr_q;
        idx      = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = PTR_W'((int'(ptr_q) + j) % NUM_REQ);
            if (!found && Req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                next_ptr     = PTR_W'((int'(idx) + 1) % NUM_REQ);
            end
        end
        if (Reset) begin
            grant_c = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
        end else if (|grant_c) begin
            ptr_q <= next_ptr;
        end
    end

    assign Grant = grant_c;
    assign Ptr   = ptr_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among ALU, MEM and DBG writeback sources
// through a one-stage write pipeline, and flags RAW hazards on the in-flight write.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int DW      = DATA_W,
    parameter int AW      = ADDR_W
) (
    input  logic Clock,
    input  logic Reset,
    regfile_write_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] grant;
    logic [AW-1:0]      sel_rd;
    logic [DW-1:0]      sel_data;
    logic               reg_write_q;
    logic [AW-1:0]      rd_q;
    logic [DW-1:0]      data_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .Clock (Clock),
        .Reset (Reset),
        .Req   (bus.Req),
        .Grant (grant),
        .Ptr   (bus.Ptr)
    );

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd   | bus.ReqRD[i*AW +: AW];
                sel_data = sel_data | bus.ReqData[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            reg_write_q <= |grant;
            if (|grant) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end

    assign bus.Grant     = grant;
    assign bus.RegWrite  = reg_write_q;
    assign bus.RD        = rd_q;
    assign bus.WriteData = data_q;
    // Reset gating keeps Stall low before the first reset edge clears RegWrite.
    assign bus.Stall     = ~Reset & reg_write_q & ((rd_q == bus.RS) | (rd_q == bus.RT));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table-driven bench for regfile_write_arbiter with a write scoreboard.
module tb_regfile_write_arbiter;
    import cpu_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] rf[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file model and write scoreboard, sampled at the write edge.
    always @(posedge Clock) begin
        if (bus.RegWrite === 1'b1) begin
            rf[bus.RD] <= bus.WriteData;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0h expected none", bus.WriteData);
            end else begin
                if (bus.WriteData !== exp_q[0]) begin
                    bad++;
                    $display("FAIL sb_data: got %0h expected %0h", bus.WriteData, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [5:0]  rd;
        logic [47:0] data;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [2:0]  grant;
        logic        rw;
        logic [1:0]  rd_o;
        logic [15:0] wd;
        logic        stall;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [5:0]  rd_rr;
        logic [47:0] d_rr;
        for (int i = 0; i < 4; i++) rf[i] = 16'h0;
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd7,
                  16'h11, 16'h22, 16'h33, 16'hBEEF};

        rd_rr = {2'd3, 2'd2, 2'd1};
        d_rr  = {16'd3, 16'd2, 16'd1};
        //              rst   req     rd                   data                        rs     rt     grant   rw    rd_o   wd       stall
        vecs[0]  = '{1'b1, 3'b111, 6'd0,                48'd0,                      2'd0, 2'd0, 3'b000, 1'b0, 2'd0, 16'd0,   1'b0};
        vecs[1]  = '{1'b1, 3'b111, 6'd0,                48'd0,                      2'd0, 2'd0, 3'b000, 1'b0, 2'd0, 16'd0,   1'b0};
        vecs[2]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b001, 1'b0, 2'd0, 16'd0,   1'b0};
        vecs[3]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b010, 1'b1, 2'd1, 16'd1,   1'b0};
        vecs[4]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b100, 1'b1, 2'd2, 16'd2,   1'b0};
        vecs[5]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b001, 1'b1, 2'd3, 16'd3,   1'b0};
        vecs[6]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b010, 1'b1, 2'd1, 16'd1,   1'b0};
        vecs[7]  = '{1'b0, 3'b111, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b100, 1'b1, 2'd2, 16'd2,   1'b0};
        vecs[8]  = '{1'b0, 3'b000, rd_rr,               d_rr,                       2'd0, 2'd0, 3'b000, 1'b1, 2'd3, 16'd3,   1'b0};
        vecs[9]  = '{1'b0, 3'b010, {2'd0, 2'd3, 2'd0},  {16'd0, 16'd7, 16'd0},      2'd3, 2'd0, 3'b010, 1'b0, 2'd3, 16'd3,   1'b0};
        vecs[10] = '{1'b0, 3'b000, {2'd0, 2'd3, 2'd0},  {16'd0, 16'd7, 16'd0},      2'd3, 2'd0, 3'b000, 1'b1, 2'd3, 16'd7,   1'b1};
        vecs[11] = '{1'b0, 3'b011, {2'd0, 2'd2, 2'd0},  {16'd0, 16'h22, 16'h11},    2'd0, 2'd0, 3'b001, 1'b0, 2'd3, 16'd7,   1'b0};
        vecs[12] = '{1'b0, 3'b011, {2'd0, 2'd2, 2'd0},  {16'd0, 16'h22, 16'h11},    2'd0, 2'd0, 3'b010, 1'b1, 2'd0, 16'h11,  1'b1};
        vecs[13] = '{1'b0, 3'b100, {2'd2, 2'd0, 2'd0},  {16'h33, 16'd0, 16'd0},     2'd2, 2'd1, 3'b100, 1'b1, 2'd2, 16'h22,  1'b1};
        vecs[14] = '{1'b0, 3'b000, {2'd2, 2'd0, 2'd0},  {16'h33, 16'd0, 16'd0},     2'd0, 2'd1, 3'b000, 1'b1, 2'd2, 16'h33,  1'b0};
        vecs[15] = '{1'b0, 3'b000, {2'd2, 2'd0, 2'd0},  {16'h33, 16'd0, 16'd0},     2'd2, 2'd1, 3'b000, 1'b0, 2'd2, 16'h33,  1'b0};

        bus.Req     = 3'b111;
        bus.ReqRD   = '0;
        bus.ReqData = '0;
        bus.RS      = '0;
        bus.RT      = '0;
        Reset       = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 16; i++) begin
            Reset       = vecs[i].rst;
            bus.Req     = vecs[i].req;
            bus.ReqRD   = vecs[i].rd;
            bus.ReqData = vecs[i].data;
            bus.RS      = vecs[i].rs;
            bus.RT      = vecs[i].rt;
            @(negedge Clock);
            check($sformatf("v%0d_grant", i), 32'(bus.Grant), 32'(vecs[i].grant));
            check($sformatf("v%0d_regwrite", i), 32'(bus.RegWrite), 32'(vecs[i].rw));
            check($sformatf("v%0d_rd", i), 32'(bus.RD), 32'(vecs[i].rd_o));
            check($sformatf("v%0d_wdata", i), 32'(bus.WriteData), 32'(vecs[i].wd));
            check($sformatf("v%0d_stall", i), 32'(bus.Stall), 32'(vecs[i].stall));
            @(posedge Clock);
            #1;
        end

        // Reset lands on the edge right after an ALU grant: the write must be dropped.
        bus.Req     = 3'b001;
        bus.ReqRD   = {2'd0, 2'd0, 2'd1};
        bus.ReqData = {16'd0, 16'd0, 16'hBEEF};
        bus.RS      = 2'd0;
        bus.RT      = 2'd0;
        @(negedge Clock);
        check("mid_grant", 32'(bus.Grant), 32'b001);
        check("mid_ptr_before", 32'(bus.Ptr), 32'd0);
        #1;
        Reset       = 1'b1;
        bus.Req     = 3'b011;
        bus.ReqRD   = {2'd0, 2'd3, 2'd1};
        bus.ReqData = {16'd0, 16'h5555, 16'hBEEF};
        @(posedge Clock);
        #1;
        check("mid_regwrite_dropped", 32'(bus.RegWrite), 32'd0);
        check("mid_ptr_reset", 32'(bus.Ptr), 32'd0);
        check("mid_grant_in_reset", 32'(bus.Grant), 32'd0);
        check("mid_stall_in_reset", 32'(bus.Stall), 32'd0);
        check("mid_rf1_kept", 32'(rf[1]), 32'd1);
        Reset = 1'b0;
        @(negedge Clock);
        check("rearb_grant", 32'(bus.Grant), 32'b001);
        @(posedge Clock);
        #1;
        bus.Req = 3'b000;
        @(negedge Clock);
        check("rearb_regwrite", 32'(bus.RegWrite), 32'd1);
        check("rearb_rd", 32'(bus.RD), 32'd1);
        check("rearb_wdata", 32'(bus.WriteData), 32'hBEEF);
        check("rearb_ptr", 32'(bus.Ptr), 32'd1);
        @(posedge Clock);
        #1;
        check("idle_regwrite", 32'(bus.RegWrite), 32'd0);

        check("rf0", 32'(rf[0]), 32'h11);
        check("rf1", 32'(rf[1]), 32'hBEEF);
        check("rf2_later_wins", 32'(rf[2]), 32'h33);
        check("rf3", 32'(rf[3]), 32'd7);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
